regfile_writeback_queue: RTL

Writer-side front end for the 32-entry register file. It buffers writeback requests from the execute stage in a small FIFO and issues at most one write per cycle on the regfile write port (`write_register`, `write_data`, `reg_write`). It can also report pending writes to two lookup addresses so the read side can bypass stale regfile data.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 73 +++++++
 rtl/regfile_writeback_queue.sv | 122 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types: address width, register count and the writeback entry layout.
// `WORD is the global data width; it defaults to 32 when no other file has set it.
`ifndef WORD
`define WORD 32
`endif

package regfile_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [`WORD-1:0]      data;
   } wb_entry_t;

   function automatic logic entry_matches(input wb_entry_t entry, input logic [REG_ADDR_W-1:0] addr);
      return entry.addr == addr;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular writeback buffer: storage, head/tail pointers and occupancy.
// Exposes every slot, a per-slot valid vector and the head pointer so the parent can search it by age.
`ifndef WORD
`define WORD 32
`endif

module wb_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  wb_entry_t        push_entry,
   output wb_entry_t        head_entry,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output wb_entry_t        entries [DEPTH],
   output logic [DEPTH-1:0] entry_valid,
   output logic [PTR_W-1:0] head_ptr
);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + CNT_W'(1);
         else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
   end

   // Payload needs no reset; entry_valid gates every use of it.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   // A slot is live when its distance from the head is below the occupancy.
   always_comb begin
      logic [PTR_W-1:0] age;
      entry_valid = '0;
      age         = '0;
      for (int s = 0; s < DEPTH; s++) begin
         age            = PTR_W'(s) - rd_ptr_q;
         entry_valid[s] = CNT_W'(age) < count_q;
      end
   end

   assign entries    = mem_q;
   assign head_entry = mem_q[rd_ptr_q];
   assign head_ptr   = rd_ptr_q;
   assign count      = count_q;
   assign full       = count_q == CNT_W'(DEPTH);
   assign empty      = count_q == '0;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writer-side front end of the register file: queues writebacks and issues one write per cycle.
// Define WB_BYPASS_EN to compile in the pending-write lookup; otherwise hit outputs are tied to 0.
`ifndef WORD
`define WORD 32
`endif

module regfile_writeback_queue
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [REG_ADDR_W-1:0]        in_register,
   input  logic [`WORD-1:0]             in_data,
   input  logic                         flush,
   input  logic                         port_busy,
   output logic [REG_ADDR_W-1:0]        write_register,
   output logic [`WORD-1:0]             write_data,
   output logic                         reg_write,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   input  logic [REG_ADDR_W-1:0]        lookup_register1,
   input  logic [REG_ADDR_W-1:0]        lookup_register2,
   output logic                         hit1,
   output logic                         hit2,
   output logic [`WORD-1:0]             hit_data1,
   output logic [`WORD-1:0]             hit_data2
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   wb_entry_t        head_entry;
   wb_entry_t        fifo_entries [DEPTH];
   logic [DEPTH-1:0] fifo_valid;
   logic [PTR_W-1:0] head_ptr;
   logic             fifo_full, fifo_empty;
   logic             push, pop;
   wb_entry_t        out_q;
   logic             reg_write_q;

   // Ready looks only at registered occupancy, so a full queue stays closed even when popping.
   assign in_ready = !fifo_full && !flush;
   assign push     = in_valid && in_ready;
   assign pop      = !fifo_empty && !port_busy && !flush;

   wb_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .pop         (pop),
      .clear       (flush),
      .push_entry  ('{addr: in_register, data: in_data}),
      .head_entry  (head_entry),
      .count       (count),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .entries     (fifo_entries),
      .entry_valid (fifo_valid),
      .head_ptr    (head_ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         reg_write_q <= 1'b0;
      end else begin
         reg_write_q <= pop;
         if (pop) out_q <= head_entry;
      end
   end

   assign reg_write      = reg_write_q;
   assign write_register = out_q.addr;
   assign write_data     = out_q.data;

`ifdef WB_BYPASS_EN
   // Walk oldest to newest so the newest matching entry wins; the output stage is oldest of all.
   always_comb begin
      logic [PTR_W-1:0] slot;
      hit1      = 1'b0;
      hit2      = 1'b0;
      hit_data1 = '0;
      hit_data2 = '0;
      slot      = '0;
      if (reg_write_q && entry_matches(out_q, lookup_register1)) begin
         hit1      = 1'b1;
         hit_data1 = out_q.data;
      end
      if (reg_write_q && entry_matches(out_q, lookup_register2)) begin
         hit2      = 1'b1;
         hit_data2 = out_q.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         slot = head_ptr + PTR_W'(i);
         if (fifo_valid[slot] && entry_matches(fifo_entries[slot], lookup_register1)) begin
            hit1      = 1'b1;
            hit_data1 = fifo_entries[slot].data;
         end
         if (fifo_valid[slot] && entry_matches(fifo_entries[slot], lookup_register2)) begin
            hit2      = 1'b1;
            hit_data2 = fifo_entries[slot].data;
         end
      end
   end
`else
   assign hit1      = 1'b0;
   assign hit2      = 1'b0;
   assign hit_data1 = '0;
   assign hit_data2 = '0;

   logic unused_bypass;
   always_comb begin
      unused_bypass = ^{lookup_register1, lookup_register2, fifo_valid, head_ptr};
      for (int i = 0; i < DEPTH; i++) unused_bypass = unused_bypass ^ (^fifo_entries[i]);
   end
`endif

endmodule
